// File: rtl/word_unpacker.sv
// word_unpacker: splits packed IN_WIDTH words from a FIFO into OUT_WIDTH lanes,
// emitting one lane per cycle, lane 0 (lowest bits) first. A short final word is
// described by in_lanes; in_last marks the end of a packet.

// Per-lane select: passes its lane through only when the lane index points at it,
// so the top level can OR all lanes together into one output mux.
module word_unpacker_lane #(
   parameter int OUT_WIDTH = 8,
   parameter int IW        = 2,
   parameter int LANE      = 0
) (
   input  logic [IW-1:0]        idx,
   input  logic [OUT_WIDTH-1:0] lane,
   output logic [OUT_WIDTH-1:0] masked
);

   assign masked = (idx == IW'(LANE)) ? lane : '0;

endmodule

module word_unpacker #(
   parameter int IN_WIDTH  = 32,
   parameter int OUT_WIDTH = 8,
   parameter int CW        = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [IN_WIDTH-1:0]  in_data,
   input  logic                 in_last,
   input  logic [CW-1:0]        in_lanes,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [OUT_WIDTH-1:0] out_data,
   output logic                 out_last
);

   localparam int N  = IN_WIDTH / OUT_WIDTH;
   localparam int IW = $clog2(N);
   localparam logic [CW-1:0] N_CW = CW'(N);

   typedef enum logic {EMPTY, BUSY} state_t;

   state_t                      state_q, state_d;
   logic [IW-1:0]               idx_q, idx_d;
   logic [N-1:0][OUT_WIDTH-1:0] word_q, word_d;
   logic                        last_q, last_d;
   logic [CW-1:0]               lanes_q, lanes_d;

   logic [CW-1:0]               lanes_clamp;
   logic                        at_end;
   logic                        accept;
   logic                        xfer;
   logic [N-1:0][OUT_WIDTH-1:0] masked;
   logic [OUT_WIDTH-1:0]        sel;

   // A lane count of zero or beyond the word width means "full word".
   assign lanes_clamp = (in_lanes == '0 || in_lanes > N_CW) ? N_CW : in_lanes;

   // Final valid lane of the held word is on the output.
   assign at_end = (CW'(idx_q) == lanes_q - CW'(1));

   // Accept a new word when idle, or on the very edge the last lane leaves,
   // which lets consecutive words stream without a bubble.
   assign in_ready  = rst && (state_q == EMPTY || (out_ready && at_end));
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == BUSY);
   assign xfer      = out_valid && out_ready;
   assign out_last  = (state_q == BUSY) && last_q && at_end;

   genvar g;
   generate
      for (g = 0; g < N; g++) begin : g_lane
         word_unpacker_lane #(
            .OUT_WIDTH (OUT_WIDTH),
            .IW        (IW),
            .LANE      (g)
         ) u_lane (
            .idx    (idx_q),
            .lane   (word_q[g]),
            .masked (masked[g])
         );
      end
   endgenerate

   // OR-combine the one-hot masked lanes into the output lane.
   always_comb begin
      sel = '0;
      for (int i = 0; i < N; i++) sel = sel | masked[i];
   end

   assign out_data = sel;

   // Next-state: load on accept, step the lane index on transfer, drain to idle.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      word_d  = word_q;
      last_d  = last_q;
      lanes_d = lanes_q;
      if (accept) begin
         state_d = BUSY;
         idx_d   = '0;
         word_d  = in_data;
         last_d  = in_last;
         lanes_d = lanes_clamp;
      end else if (xfer) begin
         if (at_end) begin
            // Clear the held word so an idle output reads as zero.
            state_d = EMPTY;
            idx_d   = '0;
            word_d  = '0;
            last_d  = 1'b0;
            lanes_d = '0;
         end else begin
            idx_d = idx_q + IW'(1);
         end
      end
   end

   // State register; reset discards any partially emitted word.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= EMPTY;
         idx_q   <= '0;
         word_q  <= '0;
         last_q  <= 1'b0;
         lanes_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         word_q  <= word_d;
         last_q  <= last_d;
         lanes_q <= lanes_d;
      end
   end

endmodule

// File: tb/tb_word_unpacker.sv
// Directed bench for word_unpacker with hand-computed lane sequences.
module tb_word_unpacker;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        in_last;
   logic [2:0]  in_lanes;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic        out_last;

   int n_chk  = 0;
   int n_pass = 0;

   word_unpacker #(.IN_WIDTH(32), .OUT_WIDTH(8), .CW(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_lanes  (in_lanes),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
      else n_pass++;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Present one word, then check cnt lanes taken from exp (lane 0 first).
   task automatic run_word(input string tag, input logic [31:0] d, input logic [2:0] ln,
                           input logic lst, input int cnt, input logic [31:0] exp);
      in_valid = 1'b1; in_data = d; in_lanes = ln; in_last = lst; out_ready = 1'b1;
      #1;
      chk({tag, "_inrdy"}, in_ready, 1);
      tick;
      in_valid = 1'b0; in_data = 32'hDEADBEEF; in_lanes = 3'd1; in_last = 1'b0;
      #1;
      for (int k = 0; k < cnt; k++) begin
         chk({tag, "_vld"}, out_valid, 1);
         chk({tag, "_data"}, out_data, exp[8*k +: 8]);
         chk({tag, "_last"}, out_last, (lst && k == cnt - 1) ? 1 : 0);
         tick;
         #1;
      end
      chk({tag, "_idle"}, out_valid, 0);
   endtask

   initial begin
      logic [7:0] b2b [8];
      logic       pat [10];
      int         j;

      b2b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01, 8'h02, 8'h03, 8'h04};
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

      rst = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_lanes = '0;
      out_ready = 1'b1;

      // reset held for 3 cycles
      for (int c = 0; c < 3; c++) begin
         tick;
         chk("rst_vld", out_valid, 0);
         chk("rst_data", out_data, 0);
         chk("rst_inrdy", in_ready, 0);
         chk("rst_last", out_last, 0);
      end
      rst = 1'b1;
      #1;
      chk("rel_inrdy", in_ready, 1);
      tick;

      // single full word
      run_word("single", 32'h44332211, 3'd4, 1'b1, 4, 32'h44332211);

      // back-to-back words with no gap cycle
      in_valid = 1'b1; in_data = 32'hDDCCBBAA; in_lanes = 3'd4; in_last = 1'b0; out_ready = 1'b1;
      tick;
      in_data = 32'h04030201; in_last = 1'b1;
      #1;
      for (int k = 0; k < 8; k++) begin
         chk("b2b_vld", out_valid, 1);
         chk("b2b_data", out_data, b2b[k]);
         chk("b2b_inrdy", in_ready, (k % 4 == 3) ? 1 : 0);
         chk("b2b_last", out_last, (k == 7) ? 1 : 0);
         tick;
         if (k == 3) in_valid = 1'b0;
         #1;
      end
      chk("b2b_idle", out_valid, 0);

      // short last word, lanes=0 and lanes>N both mean full word
      run_word("short", 32'h00CCBBAA, 3'd3, 1'b1, 3, 32'h00CCBBAA);
      run_word("lanes0", 32'h11223344, 3'd0, 1'b1, 4, 32'h11223344);
      run_word("lanes7", 32'hA1B2C3D4, 3'd7, 1'b0, 4, 32'hA1B2C3D4);

      // backpressure: out_ready 1,0,0,1,...
      in_valid = 1'b1; in_data = 32'h44332211; in_lanes = 3'd4; in_last = 1'b1; out_ready = 1'b0;
      #1;
      chk("bp_inrdy_empty", in_ready, 1);
      tick;
      in_valid = 1'b0;
      j = 0;
      for (int c = 0; c < 10; c++) begin
         out_ready = pat[c];
         #1;
         chk("bp_vld", out_valid, 1);
         chk("bp_data", out_data, 32'(8'h11 * (j + 1)));
         chk("bp_inrdy", in_ready, (pat[c] && j == 3) ? 1 : 0);
         chk("bp_last", out_last, (j == 3) ? 1 : 0);
         tick;
         if (pat[c]) j++;
      end
      #1;
      chk("bp_idle", out_valid, 0);
      out_ready = 1'b1;

      // reset mid-packet after two lanes
      in_valid = 1'b1; in_data = 32'h44332211; in_lanes = 3'd4; in_last = 1'b1;
      tick;
      in_valid = 1'b0;
      tick;
      tick;
      chk("mid_data33", out_data, 8'h33);
      #2;
      rst = 1'b0;
      #1;
      chk("mid_vld", out_valid, 0);
      chk("mid_data", out_data, 0);
      chk("mid_last", out_last, 0);
      chk("mid_inrdy", in_ready, 0);
      tick;
      rst = 1'b1;
      #1;
      for (int c = 0; c < 4; c++) begin
         chk("post_vld", out_valid, 0);
         chk("post_data", out_data, 0);
         chk("post_inrdy", in_ready, 1);
         tick;
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
